// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add / restoring divide).
// Divider datapath compiled only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wr_en_o,
  output logic [4:0]       rd_addr_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, step;
  logic [WIDTH-1:0]   opb_q;
  logic [4:0]         cnt_q;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   res_q, rd_res;
  logic [4:0]         rd_q;

  logic               accept, last;
  logic               s1, s2, a_neg, b_neg, neg_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               fast;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step, prod;
  logic [WIDTH-1:0]   mul_res;

  assign accept = start_i && !flush_i && (state_q != CALC);
  assign last   = (cnt_q == 5'd31);

  // Operand signedness, magnitudes and result sign for a new request
  always_comb begin
    s1    = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'b11);
    s2    = op_i[2] ? !op_i[0] : !op_i[1];
    a_neg = s1 && rs1_data_i[WIDTH-1];
    b_neg = s2 && rs2_data_i[WIDTH-1];
    a_mag = a_neg ? (32'd0 - rs1_data_i) : rs1_data_i;
    b_mag = b_neg ? (32'd0 - rs2_data_i) : rs2_data_i;
    if (op_i[2] && op_i[1]) neg_d = a_neg;
    else                    neg_d = a_neg ^ b_neg;
  end

`ifdef MULDIV_DIV_EN
  logic               div_ovf;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   div_val, div_res;

  // Zero divisor and signed overflow bypass the iteration
  always_comb begin
    div_ovf  = !op_i[0] &&
               (rs1_data_i == 32'h8000_0000) &&
               (rs2_data_i == 32'hFFFF_FFFF);
    fast     = op_i[2] && ((rs2_data_i == '0) || div_ovf);
    fast_res = '0;
    if (rs2_data_i == '0)
      fast_res = op_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
    else
      fast_res = op_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring-divide step on {rem, quot}
  always_comb begin
    div_sh   = {acc_q, 1'b0};
    div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, opb_q};
    if (div_diff[WIDTH+1])
      div_step = div_sh[2*WIDTH-1:0];
    else
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    div_val  = op_q[1] ? div_step[2*WIDTH-1:WIDTH]
                       : div_step[WIDTH-1:0];
    div_res  = neg_q ? (32'd0 - div_val) : div_val;
  end
`else
  // Without the divider every divide op completes at once with zero
  always_comb begin
    fast     = op_i[2];
    fast_res = '0;
  end
`endif

  // One shift-add multiply step and final sign application
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? (64'd0 - mul_step) : mul_step;
    mul_res  = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                    : prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
    step     = op_q[2] ? div_step : mul_step;
    rd_res   = op_q[2] ? div_res : mul_res;
`else
    step     = mul_step;
    rd_res   = op_q[2] ? 32'd0 : mul_res;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = fast ? DONE : CALC;
      end
      CALC: begin
        if (flush_i)   state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        if (accept)  state_d = fast ? DONE : CALC;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q  <= op_i;
      neg_q <= neg_d;
      rd_q  <= rd_addr_i;
      cnt_q <= '0;
      if (op_i[2]) begin
        acc_q <= {32'd0, a_mag};
        opb_q <= b_mag;
      end else begin
        acc_q <= {32'd0, b_mag};
        opb_q <= a_mag;
      end
      if (fast) res_q <= fast_res;
    end else if (state_q == CALC && !flush_i) begin
      acc_q <= step;
      cnt_q <= cnt_q + 5'd1;
      if (last) res_q <= rd_res;
    end
  end

  assign busy_o    = (state_q == CALC);
  assign done_o    = (state_q == DONE) && !flush_i;
  assign wr_en_o   = done_o && (rd_q != 5'd0);
  assign rd_addr_o = rd_q;
  assign result_o  = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        done_o;
  logic        wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] result_o;

  int nvec = 0;
  int nerr = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wr_en_o    (wr_en_o),
    .rd_addr_o  (rd_addr_o),
    .result_o   (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd);
    op_i       = op;
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int exp_lat,
                        input bit pulse);
    int lat;
    int nbusy;
    issue(op, a, b, rd);
    lat   = 1;
    nbusy = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) nbusy++;
      @(posedge clk_i);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy"}, nbusy, exp_lat - 1);
    chk({tag, " result"}, result_o, exp);
    chk({tag, " rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
    chk({tag, " wr_en"}, {31'd0, wr_en_o}, {31'd0, rd != 5'd0});
    if (pulse) begin
      @(posedge clk_i);
      #1;
      chk({tag, " pulse"}, {31'd0, done_o}, 32'd0);
      chk({tag, " hold"}, result_o, exp);
    end
  endtask

  initial begin
    int ndone;
    int dl;
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = 3'd0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    rd_addr_i  = '0;
    dl = DivEn ? 33 : 1;
    #1;
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst result", result_o, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op("mul7x6", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 33, 1);
    run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,
           32'h0, 33, 1);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,
           32'hFFFF_FFFE, 33, 1);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3,
           32'hFFFF_FFFF, 33, 1);
    run_op("mulneg", 3'b000, 32'hFFFF_FFFD, 32'd5, 5'd4,
           32'hFFFF_FFF1, 33, 1);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6,
           DivEn ? 32'hFFFF_FFFD : 32'd0, dl, 1);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7,
           DivEn ? 32'hFFFF_FFFF : 32'd0, dl, 1);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd8,
           DivEn ? 32'd14 : 32'd0, dl, 1);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd9,
           DivEn ? 32'd2 : 32'd0, dl, 1);
    run_op("divu0", 3'b101, 32'd5, 32'd0, 5'd10,
           DivEn ? 32'hFFFF_FFFF : 32'd0, 1, 1);
    run_op("remu0", 3'b111, 32'd5, 32'd0, 5'd10,
           DivEn ? 32'd5 : 32'd0, 1, 1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
           DivEn ? 32'h8000_0000 : 32'd0, 1, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
           32'd0, 1, 1);
    run_op("mulrd0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 33, 1);

    run_op("b2b_a", 3'b000, 32'd11, 32'd13, 5'd13, 32'd143, 33, 0);
    run_op("b2b_b", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd14,
           32'd1, 33, 1);

    issue(3'b000, 32'd7, 32'd6, 5'd3);
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("flush busy", {31'd0, busy_o}, 32'd0);
    chk("flush done", {31'd0, done_o}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o) ndone++;
    end
    chk("flush nodone", ndone, 0);
    chk("flush hold", result_o, 32'd1);

    flush_i = 1'b1;
    issue(3'b000, 32'd2, 32'd2, 5'd5);
    flush_i = 1'b0;
    chk("flush+start busy", {31'd0, busy_o}, 32'd0);
    chk("flush+start done", {31'd0, done_o}, 32'd0);

    issue(3'b000, 32'h1234, 32'h5678, 5'd7);
    repeat (19) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy_o}, 32'd0);
    chk("midrst done", {31'd0, done_o}, 32'd0);
    chk("midrst wr", {31'd0, wr_en_o}, 32'd0);
    chk("midrst result", result_o, 32'd0);
    chk("midrst rd", {27'd0, rd_addr_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_op("postrst", 3'b000, 32'd9, 32'd9, 5'd15, 32'd81, 33, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
